// File: rtl/lock_pkg.sv
// Shared definitions for the lock datapath: widths, key codes, lock state
// encoding and the keypad lockout states.
package lock_pkg;

  localparam int SEQ_W      = 32;
  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic [3:0] {
    KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3,
    KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7,
    KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB,
    KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF
  } key_code_e;

  typedef enum logic [3:0] {
    LS0   = 4'h0, LS1 = 4'h1, LS2 = 4'h2, LS3 = 4'h3,
    LS4   = 4'h4, LS5 = 4'h5, LS6 = 4'h6, LS7 = 4'h7,
    OPEN  = 4'h8,
    ALARM = 4'h9,
    INIT  = 4'hA
  } lock_state_e;

  typedef enum logic {
    KP_IDLE = 1'b0,
    KP_LOCK = 1'b1
  } kp_state_e;

  // Highest set bit wins when several hex keys rise together.
  function automatic logic [3:0] hex_prio(input logic [15:0] edges);
    logic [3:0] code;
    code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (edges[i]) begin
        code = 4'(i);
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one raw button, plus a history flop that turns
// the synchronized level into a single-cycle rising-edge flag.
module sync_edge (
  input  logic clk,
  input  logic nRst,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronizer chain and previous-value tracker.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/keypad_seq.sv
// Keypad front end: edge-detects 18 buttons, arbitrates clr > enter > hex,
// applies a post-event lockout and shifts accepted hex digits into seq.
module keypad_seq #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int MAX_DIGITS      = 8
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic [15:0]                 pb_hex,
  input  logic                        pb_enter,
  input  logic                        pb_clr,
  output logic [lock_pkg::SEQ_W-1:0]  seq,
  output logic [lock_pkg::DIGIT_W-1:0] digit_cnt,
  output logic [3:0]                  key_code,
  output logic                        strobe,
  output logic                        enter,
  output logic                        clear
);
  import lock_pkg::*;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]   LOCK_LOAD = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(MAX_DIGITS);
  localparam logic               LOCK_EN   = (DEBOUNCE_CYCLES != 0);

  logic [17:0] raw_s, rise_s;
  logic [3:0]  code_s;
  logic        accept_s;

  kp_state_e            state_q, state_d;
  logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [DIGIT_W-1:0]   digit_cnt_q, digit_cnt_d;
  logic [3:0]           key_code_q, key_code_d;
  logic                 strobe_q, strobe_d;
  logic                 enter_q, enter_d;
  logic                 clear_q, clear_d;

  assign raw_s = {pb_clr, pb_enter, pb_hex};

  genvar g;
  for (g = 0; g < 18; g++) begin : g_sync
    sync_edge u_sync (
      .clk  (clk),
      .nRst (nRst),
      .din  (raw_s[g]),
      .rise (rise_s[g])
    );
  end

  assign code_s = hex_prio(rise_s[15:0]);

  // Event arbitration, lockout sequencing and next register values.
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    seq_d       = seq_q;
    digit_cnt_d = digit_cnt_q;
    key_code_d  = key_code_q;
    strobe_d    = 1'b0;
    enter_d     = 1'b0;
    clear_d     = 1'b0;
    accept_s    = 1'b0;
    case (state_q)
      KP_IDLE: begin
        if (rise_s[17]) begin
          clear_d     = 1'b1;
          seq_d       = '0;
          digit_cnt_d = '0;
          accept_s    = 1'b1;
        end else if (rise_s[16]) begin
          enter_d  = 1'b1;
          accept_s = 1'b1;
        end else if (|rise_s[15:0]) begin
          seq_d       = {seq_q[SEQ_W-5:0], code_s};
          key_code_d  = code_s;
          strobe_d    = 1'b1;
          digit_cnt_d = (digit_cnt_q >= DIGIT_MAX) ? DIGIT_MAX : digit_cnt_q + 4'd1;
          accept_s    = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
        // A zero-length lockout never leaves IDLE.
        if (accept_s && LOCK_EN) begin
          state_d    = KP_LOCK;
          lock_cnt_d = LOCK_LOAD;
        end else begin
          state_d    = KP_IDLE;
        end
      end
      KP_LOCK: begin
        if (lock_cnt_q <= CNT_W'(1)) begin
          state_d    = KP_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d    = KP_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= KP_IDLE;
      lock_cnt_q  <= '0;
      seq_q       <= '0;
      digit_cnt_q <= '0;
      key_code_q  <= 4'h0;
      strobe_q    <= 1'b0;
      enter_q     <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      seq_q       <= seq_d;
      digit_cnt_q <= digit_cnt_d;
      key_code_q  <= key_code_d;
      strobe_q    <= strobe_d;
      enter_q     <= enter_d;
      clear_q     <= clear_d;
    end
  end

  assign seq       = seq_q;
  assign digit_cnt = digit_cnt_q;
  assign key_code  = key_code_q;
  assign strobe    = strobe_q;
  assign enter     = enter_q;
  assign clear     = clear_q;

endmodule

// File: tb/tb_keypad_seq.sv
// Bench for keypad_seq: scripted directed scenarios followed by random button
// activity, all compared every cycle against a cycle-indexed reference model.
module tb_keypad_seq;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [15:0] pb_hex = 16'h0;
  logic        pb_enter = 1'b0;
  logic        pb_clr = 1'b0;
  logic [31:0] seq;
  logic [3:0]  digit_cnt, key_code;
  logic        strobe, enter, clear;

  int checks = 0;
  int passes = 0;
  int dut_strobes = 0;
  int dut_enters = 0;
  int dut_clears = 0;

  always #5 clk = ~clk;

  keypad_seq #(.DEBOUNCE_CYCLES(L), .MAX_DIGITS(8)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .pb_hex    (pb_hex),
    .pb_enter  (pb_enter),
    .pb_clr    (pb_clr),
    .seq       (seq),
    .digit_cnt (digit_cnt),
    .key_code  (key_code),
    .strobe    (strobe),
    .enter     (enter),
    .clear     (clear)
  );

  // Reference model: a button press counts at edge E when it was sampled high
  // at E-2 and low at E-3; after an accept at edge A nothing is taken before A+L+1.
  logic [31:0] m_seq = 32'h0;
  int          m_cnt = 0;
  logic [3:0]  m_key = 4'h0;
  logic        m_strobe = 1'b0, m_enter = 1'b0, m_clear = 1'b0;
  logic [17:0] hist [$] = '{18'h0, 18'h0, 18'h0};
  int          edge_no = 0;
  int          next_ok = 0;

  always @(posedge clk or negedge nRst) begin
    logic [17:0] rise;
    int          win;
    if (!nRst) begin
      m_seq = 32'h0; m_cnt = 0; m_key = 4'h0;
      m_strobe = 1'b0; m_enter = 1'b0; m_clear = 1'b0;
      hist = '{18'h0, 18'h0, 18'h0};
      edge_no = 0; next_ok = 0;
    end else begin
      rise = hist[1] & ~hist[2];
      m_strobe = 1'b0; m_enter = 1'b0; m_clear = 1'b0;
      if (edge_no >= next_ok && rise != 18'h0) begin
        if (rise[17]) begin
          m_clear = 1'b1; m_seq = 32'h0; m_cnt = 0;
        end else if (rise[16]) begin
          m_enter = 1'b1;
        end else begin
          win = 0;
          for (int i = 0; i < 16; i++) if (rise[i]) win = i;
          m_seq = {m_seq[27:0], 4'(win)};
          m_key = 4'(win);
          m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
          m_strobe = 1'b1;
        end
        if (L > 0) next_ok = edge_no + L + 1;
      end
      hist.push_front({pb_clr, pb_enter, pb_hex});
      void'(hist.pop_back());
      edge_no++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cycle {seq,cnt,key,stb,ent,clr}",
          64'({seq, digit_cnt, key_code, strobe, enter, clear}),
          64'({m_seq, 4'(m_cnt), m_key, m_strobe, m_enter, m_clear}));
    if (strobe) dut_strobes++;
    if (enter)  dut_enters++;
    if (clear)  dut_clears++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input int k, input int hold, input int gap);
    pb_hex[k] = 1'b1;
    tick(hold);
    pb_hex[k] = 1'b0;
    tick(gap);
  endtask

  int s0;
  int r;

  initial begin
    tick(2);
    check("reset seq", 64'(seq), 64'h0);
    check("reset cnt", 64'(digit_cnt), 64'h0);
    nRst = 1'b1;
    tick(2);

    for (int k = 1; k <= 8; k++) press(k, 5, 10);
    check("seq 1..8", 64'(seq), 64'h12345678);
    check("model seq 1..8", 64'(m_seq), 64'h12345678);
    check("cnt 1..8", 64'(digit_cnt), 64'd8);
    check("strobes 1..8", 64'(dut_strobes), 64'd8);

    press(10, 5, 10);
    check("seq after A", 64'(seq), 64'h2345678A);
    check("cnt saturated", 64'(digit_cnt), 64'd8);

    press(16'd0, 0, 0);
    pb_enter = 1'b1; tick(5); pb_enter = 1'b0; tick(10);
    check("enter count", 64'(dut_enters), 64'd1);
    check("seq holds on enter", 64'(seq), 64'h2345678A);

    pb_clr = 1'b1; pb_hex[5] = 1'b1;
    tick(5);
    pb_clr = 1'b0; pb_hex[5] = 1'b0;
    tick(10);
    check("clear count", 64'(dut_clears), 64'd1);
    check("seq cleared", 64'(seq), 64'h0);
    check("cnt cleared", 64'(digit_cnt), 64'h0);
    check("no strobe with clr", 64'(dut_strobes), 64'd9);
    check("key_code holds", 64'(key_code), 64'hA);

    pb_hex = 16'h0208;
    tick(5);
    pb_hex = 16'h0;
    tick(10);
    check("key_code 3+9", 64'(key_code), 64'h9);
    check("model key 3+9", 64'(m_key), 64'h9);
    check("seq nibble 3+9", 64'(seq[3:0]), 64'h9);
    check("one strobe 3+9", 64'(dut_strobes), 64'd10);

    s0 = dut_strobes;
    for (int i = 0; i < 4; i++) begin
      pb_hex[2] = (i % 2 == 0);
      tick(1);
    end
    pb_hex[2] = 1'b0;
    check("bounce one accept", 64'(dut_strobes - s0), 64'd1);
    tick(3);
    press(7, 5, 10);
    check("press 7 after lock", 64'(dut_strobes - s0), 64'd2);
    check("seq after bounce", 64'(seq), 64'h00000927);

    s0 = dut_strobes;
    pb_hex[4] = 1'b1;
    tick(2);
    nRst = 1'b0;
    tick(2);
    check("mid reset seq", 64'(seq), 64'h0);
    check("mid reset key", 64'(key_code), 64'h0);
    check("mid reset no strobe", 64'(dut_strobes - s0), 64'd0);
    nRst = 1'b1;
    tick(5);
    check("held through release", 64'(dut_strobes - s0), 64'd1);
    check("seq after release", 64'(seq), 64'h4);
    pb_hex[4] = 1'b0;
    tick(10);

    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1: pb_hex = 16'(32'h1 << $urandom_range(0, 15));
        2:    pb_hex = 16'($urandom) & 16'($urandom);
        3, 4: pb_hex = 16'h0;
        5:    pb_enter = ($urandom_range(0, 2) == 0);
        6:    pb_clr = ($urandom_range(0, 5) == 0);
        7:    if ($urandom_range(0, 40) == 0) begin
                nRst = 1'b0;
                tick(1);
                nRst = 1'b1;
              end
        default: ;
      endcase
      tick(1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
